// File: rtl/rram_pulse_pkg.sv
// Shared types for the RRAM pulse sequencer: opcodes, FSM states and the
// queued request bundle.
package rram_pulse_pkg;

  localparam int RP_WORD_SIZE  = 48;
  localparam int RP_ADDR_BITS  = 16;
  localparam int RP_BSL_BITS   = 5;
  localparam int RP_WL_BITS    = 8;
  localparam int RP_PW_BITS    = 8;
  localparam int RP_SETUP_BITS = 4;
  localparam int RP_TMO_BITS   = 8;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_READ   = 2'd1,
    OP_CPULSE = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_SENSE,
    S_CP_BL,
    S_CP_GAP,
    S_CP_WL,
    S_DONE
  } state_e;

  typedef struct packed {
    op_e                      op;
    logic                     set_rst;
    logic [RP_ADDR_BITS-1:0]  addr;
    logic [RP_WORD_SIZE-1:0]  di;
    logic [RP_BSL_BITS-1:0]   bsl;
    logic [RP_WL_BITS-1:0]    wl;
    logic [RP_PW_BITS-1:0]    pw;
    logic [RP_SETUP_BITS-1:0] setup;
  } req_t;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rram_req_fifo.sv
// Request queue: NCH-deep FIFO of req_t; simultaneous push and pop are
// accepted even when full.
import rram_pulse_pkg::*;

module rram_req_fifo #(
  parameter int NCH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  req_t wdata,
  input  logic pop,
  output req_t rdata,
  output logic full,
  output logic empty
);

  localparam int AW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNTW = $clog2(NCH + 1);
  localparam logic [AW-1:0] LAST = AW'(NCH - 1);

  req_t            mem_q [NCH];
  logic [AW-1:0]   wp_q, wp_d;
  logic [AW-1:0]   rp_q, rp_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full    = (cnt_q == CNTW'(NCH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rp_q];

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (do_push) wp_d = (wp_q == LAST) ? '0 : wp_q + 1'b1;
    if (do_pop)  rp_d = (rp_q == LAST) ? '0 : rp_q + 1'b1;
    cnt_d = cnt_q + CNTW'(do_push) - CNTW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= wdata;
  end

endmodule

// File: rtl/rram_pulse_seq.sv
// RRAM pulse sequencer: pops queued write/read/charge-pulse requests and
// plays each one out as a cycle-exact analog control waveform.
import rram_pulse_pkg::*;

module rram_pulse_seq #(
  parameter int WORD_SIZE  = RP_WORD_SIZE,
  parameter int ADDR_BITS  = RP_ADDR_BITS,
  parameter int BSL_BITS   = RP_BSL_BITS,
  parameter int WL_BITS    = RP_WL_BITS,
  parameter int PW_BITS    = RP_PW_BITS,
  parameter int SETUP_BITS = RP_SETUP_BITS,
  parameter int TMO_BITS   = RP_TMO_BITS,
  parameter int NCH        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic                  req_set_rst,
  input  logic [ADDR_BITS-1:0]  req_addr,
  input  logic [WORD_SIZE-1:0]  req_di,
  input  logic [BSL_BITS-1:0]   req_bsl,
  input  logic [WL_BITS-1:0]    req_wl,
  input  logic [PW_BITS-1:0]    req_pw,
  input  logic [SETUP_BITS-1:0] req_setup,
  input  logic                  all_dacs_on,
  input  logic                  sa_rdy,
  input  logic [WORD_SIZE-1:0]  sa_do,
  output logic                  bl_en,
  output logic                  sl_en,
  output logic                  wl_en,
  output logic                  we,
  output logic                  aclk,
  output logic                  sa_en,
  output logic                  bsl_dac_en,
  output logic                  wl_dac_en,
  output logic                  bleed_en,
  output logic                  read_dac_en,
  output logic                  set_rst,
  output logic [WORD_SIZE-1:0]  di,
  output logic [ADDR_BITS-1:0]  rram_addr,
  output logic [BSL_BITS-1:0]   bsl_dac_config,
  output logic [WL_BITS-1:0]    wl_dac_config,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_op,
  output logic [WORD_SIZE-1:0]  rsp_data,
  output logic                  rsp_timeout
);

  localparam int CW = cnt_width(PW_BITS, SETUP_BITS, TMO_BITS);
  localparam logic [CW-1:0] TMO_LAST = CW'((1 << TMO_BITS) - 2);

  req_t                 in_req, head, cur_q, cur_d;
  logic                 full, empty, push, pop;
  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 tmo_q, tmo_d;
  logic                 run_q;

  function automatic logic [CW-1:0] pw_m1(input logic [PW_BITS-1:0] pw);
    return (pw == '0) ? '0 : CW'(pw - 1'b1);
  endfunction

  always_comb begin
    in_req         = '0;
    in_req.op      = op_e'(req_op);
    in_req.set_rst = req_set_rst;
    in_req.addr    = req_addr;
    in_req.di      = req_di;
    in_req.bsl     = req_bsl;
    in_req.wl      = req_wl;
    in_req.pw      = req_pw;
    in_req.setup   = req_setup;
  end

  assign req_ready = !full;
  assign push      = req_valid && req_ready;

  rram_req_fifo #(.NCH(NCH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_req),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    rdata_d = rdata_q;
    tmo_d   = tmo_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cur_d   = head;
          rdata_d = '0;
          tmo_d   = 1'b0;
          unique case (head.op)
            OP_WRITE, OP_READ: begin
              cnt_d   = CW'(head.setup);
              state_d = S_SETUP;
            end
            OP_CPULSE: begin
              cnt_d   = pw_m1(head.pw);
              state_d = S_CP_BL;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_SETUP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (cur_q.op == OP_WRITE) begin
          cnt_d   = pw_m1(cur_q.pw);
          state_d = S_PULSE;
        end else begin
          cnt_d   = TMO_LAST;
          state_d = S_SENSE;
        end
      end
      S_PULSE, S_CP_WL: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = S_DONE;
      end
      // sense data wins over a timeout landing on the same cycle
      S_SENSE: begin
        if (sa_rdy) begin
          rdata_d = sa_do;
          state_d = S_DONE;
        end else if (cnt_q == '0) begin
          rdata_d = '0;
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CP_BL: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = S_CP_GAP;
      end
      S_CP_GAP: begin
        cnt_d   = pw_m1(cur_q.pw);
        state_d = S_CP_WL;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      rdata_q <= '0;
      tmo_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      rdata_q <= rdata_d;
      tmo_q   <= tmo_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    bl_en       = 1'b0;
    sl_en       = 1'b0;
    wl_en       = 1'b0;
    we          = 1'b0;
    aclk        = 1'b0;
    sa_en       = 1'b0;
    bsl_dac_en  = 1'b0;
    wl_dac_en   = 1'b0;
    bleed_en    = 1'b0;
    read_dac_en = 1'b0;
    unique case (state_q)
      S_SETUP, S_PULSE, S_SENSE: begin
        bl_en = 1'b1;
        sl_en = 1'b1;
        wl_en = 1'b1;
        if (cur_q.op == OP_WRITE) begin
          bsl_dac_en = 1'b1;
          wl_dac_en  = 1'b1;
        end else begin
          bleed_en    = 1'b1;
          read_dac_en = 1'b1;
        end
        we    = (state_q == S_PULSE);
        aclk  = (state_q == S_PULSE);
        sa_en = (state_q == S_SENSE);
      end
      S_CP_BL: begin
        bl_en = 1'b1;
        sl_en = 1'b1;
        we    = 1'b1;
      end
      S_CP_GAP: begin
        sl_en = 1'b1;
        we    = 1'b1;
      end
      S_CP_WL: begin
        sl_en = 1'b1;
        wl_en = 1'b1;
        we    = 1'b1;
      end
      default: ;
    endcase
    // run_q is low through reset, so the override never leaks into it
    if (all_dacs_on && run_q) begin
      bsl_dac_en  = 1'b1;
      wl_dac_en   = 1'b1;
      bleed_en    = 1'b1;
      read_dac_en = 1'b1;
    end
  end

  assign set_rst        = cur_q.set_rst;
  assign di             = cur_q.di;
  assign rram_addr      = cur_q.addr;
  assign bsl_dac_config = cur_q.bsl;
  assign wl_dac_config  = cur_q.wl;
  assign rsp_valid      = (state_q == S_DONE);
  assign rsp_op         = cur_q.op;
  assign rsp_data       = rdata_q;
  assign rsp_timeout    = tmo_q;

endmodule

// File: tb/tb_rram_pulse_seq.sv
// Scoreboard bench for rram_pulse_seq: expected responses and waveform
// cycle counts are queued at request acceptance and checked on rsp_valid.
module tb_rram_pulse_seq;

  localparam int SENSE_MAX = (1 << 8) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic        req_set_rst = 1'b0;
  logic [15:0] req_addr = '0;
  logic [47:0] req_di = '0;
  logic [4:0]  req_bsl = '0;
  logic [7:0]  req_wl = '0;
  logic [7:0]  req_pw = '0;
  logic [3:0]  req_setup = '0;
  logic        all_dacs_on = 1'b0;
  logic        sa_rdy = 1'b0;
  logic [47:0] sa_do = '0;
  logic        bl_en, sl_en, wl_en, we, aclk, sa_en;
  logic        bsl_dac_en, wl_dac_en, bleed_en, read_dac_en;
  logic        set_rst;
  logic [47:0] di;
  logic [15:0] rram_addr;
  logic [4:0]  bsl_dac_config;
  logic [7:0]  wl_dac_config;
  logic        rsp_valid;
  logic [1:0]  rsp_op;
  logic [47:0] rsp_data;
  logic        rsp_timeout;

  rram_pulse_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_set_rst(req_set_rst),
    .req_addr(req_addr), .req_di(req_di),
    .req_bsl(req_bsl), .req_wl(req_wl),
    .req_pw(req_pw), .req_setup(req_setup),
    .all_dacs_on(all_dacs_on),
    .sa_rdy(sa_rdy), .sa_do(sa_do),
    .bl_en(bl_en), .sl_en(sl_en), .wl_en(wl_en),
    .we(we), .aclk(aclk), .sa_en(sa_en),
    .bsl_dac_en(bsl_dac_en), .wl_dac_en(wl_dac_en),
    .bleed_en(bleed_en), .read_dac_en(read_dac_en),
    .set_rst(set_rst), .di(di), .rram_addr(rram_addr),
    .bsl_dac_config(bsl_dac_config),
    .wl_dac_config(wl_dac_config),
    .rsp_valid(rsp_valid), .rsp_op(rsp_op),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [47:0] data;
    logic        tmo;
    logic [15:0] addr;
    logic [47:0] di;
    logic        sr;
    logic [4:0]  bsl;
    logic [7:0]  wl;
    int          n_we, n_aclk, n_wl, n_bl, n_sl, n_sa, n_pre;
  } exp_t;

  typedef struct {
    int          lat;
    logic [47:0] data;
  } rd_t;

  exp_t exp_q[$];
  rd_t  rd_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_rsp = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, req, $time);
    end
  endtask

  // sense-amp responder: answers the head read after its chosen latency
  rd_t cur_rd;
  bit  sn_act = 0;
  int  sn_cnt = 0;
  always @(negedge clk) begin
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    if (sa_en) begin
      if (!sn_act) begin
        sn_act = 1;
        sn_cnt = 0;
        if (rd_q.size() > 0) cur_rd = rd_q.pop_front();
        else cur_rd = '{lat: 0, data: '0};
      end
      sn_cnt++;
      if (cur_rd.lat != 0 && sn_cnt == cur_rd.lat) begin
        sa_rdy = 1'b1;
        sa_do  = cur_rd.data;
      end else begin
        sa_rdy = 1'b0;
        sa_do  = r[47:0];
      end
    end else begin
      sn_act = 0;
      sa_rdy = 1'($urandom_range(0, 1));
      sa_do  = r[47:0];
    end
  end

  int c_we, c_aclk, c_wl, c_bl, c_sl, c_sa, c_pre, bad_stab;
  exp_t e_m;
  always @(negedge clk) begin
    if (rst) begin
      c_we = 0; c_aclk = 0; c_wl = 0; c_bl = 0;
      c_sl = 0; c_sa = 0; c_pre = 0; bad_stab = 0;
    end else begin
      if (we)   c_we++;
      if (aclk) c_aclk++;
      if (wl_en) c_wl++;
      if (bl_en) c_bl++;
      if (sl_en) c_sl++;
      if (sa_en) c_sa++;
      if (wl_en && !we && !sa_en) c_pre++;
      if ((bl_en || sl_en || wl_en) && exp_q.size() > 0) begin
        if (rram_addr !== exp_q[0].addr || di !== exp_q[0].di ||
            set_rst !== exp_q[0].sr ||
            bsl_dac_config !== exp_q[0].bsl ||
            wl_dac_config !== exp_q[0].wl)
          bad_stab++;
      end
      if (rsp_valid) begin
        n_rsp++;
        chk("rsp_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e_m = exp_q.pop_front();
          chk("rsp_op", 64'(rsp_op), 64'(e_m.op));
          chk("rsp_timeout", 64'(rsp_timeout), 64'(e_m.tmo));
          if (e_m.op == 2'd1)
            chk("rsp_data", 64'(rsp_data), 64'(e_m.data));
          chk("we_cycles", 64'(c_we), 64'(e_m.n_we));
          chk("aclk_cycles", 64'(c_aclk), 64'(e_m.n_aclk));
          chk("wl_cycles", 64'(c_wl), 64'(e_m.n_wl));
          chk("bl_cycles", 64'(c_bl), 64'(e_m.n_bl));
          chk("sl_cycles", 64'(c_sl), 64'(e_m.n_sl));
          chk("sa_cycles", 64'(c_sa), 64'(e_m.n_sa));
          chk("settle_cycles", 64'(c_pre), 64'(e_m.n_pre));
          chk("fields_stable", 64'(bad_stab), 0);
          chk("done_enables_low",
              64'({bl_en, sl_en, wl_en, we, aclk, sa_en}), 0);
        end
        c_we = 0; c_aclk = 0; c_wl = 0; c_bl = 0;
        c_sl = 0; c_sa = 0; c_pre = 0; bad_stab = 0;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic sr,
                       input logic [15:0] a, input logic [47:0] d,
                       input logic [4:0] b, input logic [7:0] w,
                       input logic [7:0] pw, input logic [3:0] su,
                       input int lat, input logic [47:0] sd,
                       input bit want_rsp);
    exp_t e;
    rd_t  r;
    int   pe, s;
    bit   ok;
    req_op = op; req_set_rst = sr; req_addr = a; req_di = d;
    req_bsl = b; req_wl = w; req_pw = pw; req_setup = su;
    req_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    chk("req_accept", 64'(req_ready), 1);
    if (!ok) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    pe = (pw == 0) ? 1 : int'(pw);
    s  = (lat == 0) ? SENSE_MAX : lat;
    e = '{op: op, data: '0, tmo: 1'b0, addr: a, di: d, sr: sr,
          bsl: b, wl: w, n_we: 0, n_aclk: 0, n_wl: 0, n_bl: 0,
          n_sl: 0, n_sa: 0, n_pre: 0};
    case (op)
      2'd0: begin
        e.n_we = pe; e.n_aclk = pe;
        e.n_wl = int'(su) + 1 + pe;
        e.n_bl = e.n_wl; e.n_sl = e.n_wl;
        e.n_pre = int'(su) + 1;
      end
      2'd1: begin
        e.n_sa = s;
        e.n_wl = int'(su) + 1 + s;
        e.n_bl = e.n_wl; e.n_sl = e.n_wl;
        e.n_pre = int'(su) + 1;
        e.tmo  = (lat == 0);
        e.data = (lat == 0) ? '0 : sd;
        r.lat = lat; r.data = sd;
        rd_q.push_back(r);
      end
      2'd2: begin
        e.n_we = 2 * pe + 1; e.n_sl = 2 * pe + 1;
        e.n_bl = pe; e.n_wl = pe;
      end
      default: ;
    endcase
    if (want_rsp && op != 2'd3) exp_q.push_back(e);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) ok = 1;
    end
    chk("drain_queue", 64'(exp_q.size()), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_sig_we_or_wl(input bit use_we);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (use_we ? we : wl_en) ok = 1;
    end
    chk(use_we ? "see_we" : "see_wl_en", 64'(ok), 1);
  endtask

  function automatic logic [63:0] outs_or();
    return 64'({bl_en, sl_en, wl_en, we, aclk, sa_en, bsl_dac_en,
                wl_dac_en, bleed_en, read_dac_en, set_rst, rsp_valid,
                rsp_timeout, |di, |rram_addr, |bsl_dac_config,
                |wl_dac_config, |rsp_op, |rsp_data});
  endfunction

  initial begin
    int n0;
    logic [63:0] t;
    all_dacs_on = 1'b1;
    #23;
    chk("reset_outputs", outs_or(), 0);
    chk("reset_ready", 64'(req_ready), 1);
    @(negedge clk);
    all_dacs_on = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    issue(2'd0, 1'b1, 16'h0012, 48'hFFFF, 5'h0A, 8'h5C,
          8'd4, 4'd2, 0, '0, 1);
    wait_idle();
    issue(2'd1, 1'b0, 16'h0100, 48'h0, 5'h03, 8'h21,
          8'd1, 4'd0, 5, 48'hABCD, 1);
    wait_idle();
    issue(2'd1, 1'b0, 16'h0200, 48'h0, 5'h03, 8'h21,
          8'd1, 4'd1, 0, 48'h1234, 1);
    wait_idle();
    issue(2'd1, 1'b1, 16'h0201, 48'h0, 5'h04, 8'h22,
          8'd1, 4'd0, SENSE_MAX, 48'h9876_5432_10FE, 1);
    wait_idle();
    issue(2'd2, 1'b1, 16'h0300, 48'h55, 5'h1F, 8'hFF,
          8'd2, 4'd0, 0, '0, 1);
    wait_idle();
    issue(2'd2, 1'b0, 16'h0301, 48'h66, 5'h01, 8'h01,
          8'd0, 4'd3, 0, '0, 1);
    issue(2'd0, 1'b0, 16'h0302, 48'h77, 5'h02, 8'h02,
          8'd0, 4'd0, 0, '0, 1);
    issue(2'd3, 1'b1, 16'h0303, 48'h88, 5'h03, 8'h03,
          8'd5, 4'd5, 0, '0, 1);
    wait_idle();

    issue(2'd0, 1'b1, 16'h0400, 48'h1, 5'h05, 8'h05,
          8'd40, 4'd15, 0, '0, 1);
    wait_sig_we_or_wl(0);
    @(posedge clk); #1;
    issue(2'd1, 1'b0, 16'h0401, 48'h2, 5'h06, 8'h06,
          8'd3, 4'd2, 7, 48'hC0FFEE, 1);
    issue(2'd2, 1'b1, 16'h0402, 48'h3, 5'h07, 8'h07,
          8'd3, 4'd1, 0, '0, 1);
    req_op = 2'd0; req_addr = 16'h0403; req_valid = 1'b1;
    @(negedge clk);
    chk("ready_low_when_full", 64'(req_ready), 0);
    issue(2'd0, 1'b0, 16'h0403, 48'h4, 5'h08, 8'h08,
          8'd2, 4'd0, 0, '0, 1);
    wait_idle();

    issue(2'd0, 1'b1, 16'h0500, 48'hF0F0, 5'h09, 8'h09,
          8'd6, 4'd1, 0, '0, 0);
    issue(2'd0, 1'b0, 16'h0501, 48'h0F0F, 5'h0A, 8'h0A,
          8'd3, 4'd0, 0, '0, 0);
    wait_sig_we_or_wl(1);
    @(posedge clk); #2;
    chk("pulse_cycle2_we", 64'(we), 1);
    n0 = n_rsp;
    rst = 1'b1;
    #1;
    chk("abort_outputs", outs_or(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    chk("abort_no_rsp", 64'(n_rsp - n0), 0);
    issue(2'd0, 1'b1, 16'h0600, 48'hBEEF, 5'h0B, 8'h0B,
          8'd3, 4'd1, 0, '0, 1);
    wait_idle();

    all_dacs_on = 1'b1;
    issue(2'd1, 1'b0, 16'h0700, 48'h0, 5'h0C, 8'h0C,
          8'd1, 4'd2, 10, 48'h0000_1111_2222, 1);
    for (int i = 0; i < 50 && !sa_en; i++) @(negedge clk);
    chk("dacs_forced_read",
        64'({sa_en, bsl_dac_en, wl_dac_en, bleed_en, read_dac_en}),
        64'h1F);
    wait_idle();
    all_dacs_on = 1'b0;

    for (int k = 0; k < 40; k++) begin
      t = {$urandom(), $urandom()};
      issue(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            16'($urandom()), t[47:0], 5'($urandom()), 8'($urandom()),
            8'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            int'($urandom_range(1, 30)), t[63:16], 1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rram_pulse_seq.md
Name: rram_pulse_seq

Overview:
Parametrised pulse sequencer. It turns one queued write, read or test-charge-pulse request into the cycle-exact RRAM analog-block control waveform, with enable ordering, pulse width and settle timing all programmable per request. It sits between the programming FSM (request/response handshake) and the analog block, and replaces the fixed pulse timing that used to be hard-wired in the FSM. Relative to that timing it adds per-request setup and pulse counts, a read timeout, and a queue of NCH requests.

Parameters:
WORD_SIZE, 48, data/di/sa_do width
ADDR_BITS, 16, RRAM address width
BSL_BITS, 5, BL/SL DAC config width
WL_BITS, 8, WL DAC config width
PW_BITS, 8, pulse-width counter width
SETUP_BITS, 4, settle counter width
TMO_BITS, 8, read-timeout counter width
NCH, 2, request queue depth (power of 2, ≥1)

Ports:
clk in 1 clock
rst in 1 async active-high reset
req_valid in 1 request offered
req_ready out 1 queue not full
req_op in 2 0=WRITE 1=READ 2=CPULSE 3=reserved (dropped, no response)
req_set_rst in 1 1=SET 0=RESET
req_addr in ADDR_BITS target address
req_di in WORD_SIZE bit mask
req_bsl, req_wl in BSL_BITS/WL_BITS DAC levels
req_pw in PW_BITS pulse width (0 treated as 1)
req_setup in SETUP_BITS settle cycles
all_dacs_on in 1 force all DAC enables high
sa_rdy in 1 sense done
sa_do in WORD_SIZE sense data
bl_en, sl_en, wl_en, we, aclk, sa_en out 1 each analog controls
bsl_dac_en, wl_dac_en, bleed_en, read_dac_en out 1 each DAC enables
set_rst out 1 polarity
di out WORD_SIZE data-in mask
rram_addr out ADDR_BITS address
bsl_dac_config out BSL_BITS BL/SL DAC level
wl_dac_config out WL_BITS WL DAC level
rsp_valid out 1 one-cycle completion strobe
rsp_op out 2 completed opcode
rsp_data out WORD_SIZE captured sa_do (reads)
rsp_timeout out 1 read ended by timeout

Behaviour:
- rst asserted: all outputs 0 immediately, queue emptied, state IDLE. Reset mid-pulse drops we/wl_en the same instant; the aborted request gets no response.
- Queue: FIFO of depth NCH. req_ready = !full. Push on req_valid&&req_ready; a push and a pop in the same cycle are both legal when full.
- IDLE: pop the head the cycle after it becomes non-empty; latch its fields; go to SETUP (WRITE/READ) or CP_BL (CPULSE).
- SETUP: bl_en=sl_en=wl_en=1.
  - WRITE: bsl_dac_en=wl_dac_en=1.
  - READ: bleed_en=read_dac_en=1.
  - rram_addr, di, set_rst and configs are driven and stable.
  - Remain req_setup+1 cycles, then go to PULSE (WRITE) or SENSE (READ).
- PULSE: we=aclk=1 for max(req_pw,1) cycles; all other outputs held stable. Then DONE.
- SENSE: sa_en=1. Exit on the first cycle sa_rdy=1: rsp_data←sa_do, rsp_timeout=0.
  - If sa_rdy is still 0 after 2^TMO_BITS-1 cycles: rsp_data=0, rsp_timeout=1.
  - sa_rdy outside SENSE is ignored.
- CPULSE (aclk stays 0):
  - CP_BL: bl_en=sl_en=we=1, wl_en=0, for max(req_pw,1) cycles.
  - CP_GAP: bl_en=0, one cycle.
  - CP_WL: wl_en=1, for max(req_pw,1) cycles.
  - Then DONE: sl_en, wl_en and we all fall together.
- DONE: every enable deasserts. rsp_valid=1 for exactly this cycle. Next state IDLE.
- Back-to-back throughput: minimum one idle cycle between requests.
- all_dacs_on=1 forces bsl_dac_en, wl_dac_en, bleed_en and read_dac_en to 1 in every state except reset.
- Write invariant: aclk==we except in CPULSE states.
- Counters saturate; they never wrap.

Decomposition:
- Package rram_pulse_pkg holds:
  - op_e (WRITE/READ/CPULSE/RSVD)
  - state_e (IDLE, SETUP, PULSE, SENSE, CP_BL, CP_GAP, CP_WL, DONE)
  - req_t packed struct
- Sub-module rram_req_fifo: parametrised NCH×req_t synchronous FIFO with async-high reset.

Test Plan:
1. WRITE: set_rst=1, addr=0x0012, di=0xFFFF, pw=4, setup=2 → bl/sl/wl_en rise at T; we=aclk=1 T+3..T+6; fall at T+7; rsp_valid at T+7; addr/di stable throughout.
2. READ: setup=0, sa_rdy returned 5 cycles after sa_en rises, sa_do=0xABCD → rsp_data=0xABCD, rsp_timeout=0; sa_en lasts 5 cycles.
3. READ with sa_rdy held 0 → rsp_timeout=1 after 255 sense cycles, rsp_data=0, all enables low afterwards.
4. CPULSE: pw=2 → bl_en high 2 cycles, 1-cycle gap, wl_en high 2 cycles, then sl/wl/we fall together; aclk=0 throughout.
5. Queue: three requests back-to-back with NCH=2 → req_ready=0 on the third until the first pops; responses come in order with no drops.
6. Assert rst during PULSE cycle 2 → all outputs 0 asynchronously, no rsp_valid; next request after release executes normally. Also: all_dacs_on=1 during a READ → bsl_dac_en=wl_dac_en=1.
